read_data_return_router: RTL and testbench



---
 rtl/read_data_return_router.sv | 175 +++++++++++++++++
 tb/tb_read_data_return_router.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_data_return_router.sv
// read_data_return_router: AXI R-channel return path. Round-robin grant over
// four slave R ports, grant held for a whole burst, beats steered to the
// master selected by the RID sampled at grant time.
module read_data_return_router #(
    parameter int unsigned Num_OF_Masters  = 2,
    parameter int unsigned Masters_ID_Size = $clog2(Num_OF_Masters),
    parameter int unsigned Num_Of_Slaves   = 4,
    parameter int unsigned Data_width      = 32
) (
    input  logic                                     ACLK,
    input  logic                                     ARESETN,
    input  logic [Num_Of_Slaves-1:0]                 S_AXI_rvalid,
    input  logic [Num_Of_Slaves*Masters_ID_Size-1:0] S_AXI_rid,
    input  logic [Num_Of_Slaves*Data_width-1:0]      S_AXI_rdata,
    input  logic [Num_Of_Slaves*2-1:0]               S_AXI_rresp,
    input  logic [Num_Of_Slaves-1:0]                 S_AXI_rlast,
    output logic [Num_Of_Slaves-1:0]                 S_AXI_rready,
    output logic [Num_OF_Masters-1:0]                M_AXI_rvalid,
    output logic [Data_width-1:0]                    M_AXI_rdata,
    output logic [1:0]                               M_AXI_rresp,
    output logic                                     M_AXI_rlast,
    input  logic [Num_OF_Masters-1:0]                M_AXI_rready,
    output logic                                     Busy,
    output logic [7:0]                               Beat_Cnt,
    output logic                                     Err_Bad_ID
);

    localparam int unsigned NS    = Num_Of_Slaves;
    localparam int unsigned IDW   = Masters_ID_Size;
    localparam int unsigned SLV_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SLV_W-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [SLV_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               err_q, err_d;

    // Per-slave views of the flattened input buses
    logic [IDW-1:0]        sl_id   [NS];
    logic [Data_width-1:0] sl_data [NS];
    logic [1:0]            sl_resp [NS];

    // Arbitration results
    logic                  arb_found;
    logic [SLV_W-1:0]      arb_winner;
    logic [SLV_W-1:0]      arb_idx;

    // Routing helpers
    logic                  gid_ok;
    logic                  sel_valid;
    logic                  sel_ready;
    logic                  hs;

    // RID values at or beyond the master count have no destination port
    function automatic logic id_ok(input logic [IDW-1:0] id);
        return 32'(id) < 32'(Num_OF_Masters);
    endfunction

    // Split the flattened slave buses into per-slave slices
    always_comb begin
        for (int i = 0; i < int'(NS); i++) begin
            sl_id[i]   = S_AXI_rid[i*int'(IDW) +: IDW];
            sl_data[i] = S_AXI_rdata[i*int'(Data_width) +: Data_width];
            sl_resp[i] = S_AXI_rresp[i*2 +: 2];
        end
    end

    // Round-robin scan starting at rr_ptr, ascending with wrap
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = rr_ptr_q;
        arb_idx    = '0;
        for (int k = 0; k < int'(NS); k++) begin
            arb_idx = rr_ptr_q + SLV_W'(k);
            if (!arb_found && S_AXI_rvalid[arb_idx]) begin
                arb_found  = 1'b1;
                arb_winner = arb_idx;
            end
        end
    end

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gid_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gid_q      <= gid_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state and routing; data path is combinational from the held grant
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gid_d        = gid_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        M_AXI_rvalid = '0;
        S_AXI_rready = '0;
        M_AXI_rdata  = '0;
        M_AXI_rresp  = '0;
        M_AXI_rlast  = 1'b0;
        gid_ok       = id_ok(gid_q);
        sel_valid    = S_AXI_rvalid[gnt_q];
        sel_ready    = 1'b0;
        hs           = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d    = BURST;
                    gnt_d      = arb_winner;
                    gid_d      = sl_id[arb_winner];
                    beat_cnt_d = '0;
                    if (!id_ok(sl_id[arb_winner])) begin
                        err_d = 1'b1;
                    end
                end
            end

            BURST: begin
                M_AXI_rdata = sl_data[gnt_q];
                M_AXI_rresp = sl_resp[gnt_q];
                M_AXI_rlast = S_AXI_rlast[gnt_q];
                if (gid_ok) begin
                    for (int unsigned m = 0; m < Num_OF_Masters; m++) begin
                        if (32'(gid_q) == m) begin
                            M_AXI_rvalid[m] = sel_valid;
                            sel_ready       = M_AXI_rready[m];
                        end
                    end
                end else begin
                    // No destination: drain the burst so the slave is not wedged
                    sel_ready = 1'b1;
                end
                S_AXI_rready[gnt_q] = sel_ready;
                hs = sel_valid & sel_ready;
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (S_AXI_rlast[gnt_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = gnt_q + SLV_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy       = (state_q == BURST);
    assign Beat_Cnt   = beat_cnt_q;
    assign Err_Bad_ID = err_q;

endmodule

// File: tb/tb_read_data_return_router.sv
// Directed bench for read_data_return_router with a 2-bit RID so that an
// out-of-range master index can be presented.
module tb_read_data_return_router;

    localparam int unsigned NM  = 2;
    localparam int unsigned IDW = 2;
    localparam int unsigned NS  = 4;
    localparam int unsigned DW  = 32;

    logic              clk;
    logic              rst_n;
    logic [NS-1:0]     s_valid;
    logic [NS-1:0]     s_last;
    logic [IDW-1:0]    s_id   [NS];
    logic [DW-1:0]     s_data [NS];
    logic [1:0]        s_resp [NS];
    logic [NS*IDW-1:0] rid_bus;
    logic [NS*DW-1:0]  data_bus;
    logic [NS*2-1:0]   resp_bus;
    logic [NS-1:0]     s_ready;
    logic [NM-1:0]     m_valid;
    logic [DW-1:0]     m_data;
    logic [1:0]        m_resp;
    logic              m_last;
    logic [NM-1:0]     m_ready;
    logic              busy;
    logic [7:0]        beat_cnt;
    logic              err;

    int vectors;
    int miscompares;

    always_comb begin
        rid_bus  = '0;
        data_bus = '0;
        resp_bus = '0;
        for (int i = 0; i < int'(NS); i++) begin
            rid_bus[i*int'(IDW) +: IDW] = s_id[i];
            data_bus[i*int'(DW) +: DW]  = s_data[i];
            resp_bus[i*2 +: 2]          = s_resp[i];
        end
    end

    read_data_return_router #(
        .Num_OF_Masters (NM),
        .Masters_ID_Size(IDW),
        .Num_Of_Slaves  (NS),
        .Data_width     (DW)
    ) dut (
        .ACLK        (clk),
        .ARESETN     (rst_n),
        .S_AXI_rvalid(s_valid),
        .S_AXI_rid   (rid_bus),
        .S_AXI_rdata (data_bus),
        .S_AXI_rresp (resp_bus),
        .S_AXI_rlast (s_last),
        .S_AXI_rready(s_ready),
        .M_AXI_rvalid(m_valid),
        .M_AXI_rdata (m_data),
        .M_AXI_rresp (m_resp),
        .M_AXI_rlast (m_last),
        .M_AXI_rready(m_ready),
        .Busy        (busy),
        .Beat_Cnt    (beat_cnt),
        .Err_Bad_ID  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_valid = '0;
        s_last  = '0;
        m_ready = '0;
        for (int i = 0; i < int'(NS); i++) begin
            s_id[i]   = '0;
            s_data[i] = '0;
            s_resp[i] = '0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #3;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b exp 0", busy); end
        vectors++; if (beat_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_beat_cnt: got %0d exp 0", beat_cnt); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b exp 0", err); end
        vectors++; if (m_valid !== 2'b00) begin miscompares++; $display("FAIL reset_m_valid: got %b exp 00", m_valid); end
        vectors++; if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_s_ready: got %b exp 0000", s_ready); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_burst();
        clear_inputs();
        s_id[2]    = 2'd1;
        s_data[2]  = 32'hA0;
        s_valid[2] = 1'b1;
        m_ready    = 2'b10;
        #1;
        vectors++; if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL single_idle_ready: got %b exp 0000", s_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy: got %b exp 0", busy); end
        step();
        for (int b = 0; b < 4; b++) begin
            s_data[2] = 32'hA0 + 32'(b);
            s_last[2] = (b == 3);
            #1;
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy beat %0d: got %b exp 1", b, busy); end
            vectors++; if (m_valid !== 2'b10) begin miscompares++; $display("FAIL single_m_valid beat %0d: got %b exp 10", b, m_valid); end
            vectors++; if (s_ready !== 4'b0100) begin miscompares++; $display("FAIL single_s_ready beat %0d: got %b exp 0100", b, s_ready); end
            vectors++; if (m_data !== 32'hA0 + 32'(b)) begin miscompares++; $display("FAIL single_data beat %0d: got %h exp %h", b, m_data, 32'hA0 + 32'(b)); end
            vectors++; if (m_last !== (b == 3)) begin miscompares++; $display("FAIL single_last beat %0d: got %b", b, m_last); end
            vectors++; if (beat_cnt !== 8'(b)) begin miscompares++; $display("FAIL single_cnt beat %0d: got %0d exp %0d", b, beat_cnt, b); end
            step();
        end
        s_valid[2] = 1'b0;
        s_last[2]  = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_end_busy: got %b exp 0", busy); end
        vectors++; if (beat_cnt !== 8'd4) begin miscompares++; $display("FAIL single_end_cnt: got %0d exp 4", beat_cnt); end
        // rr_ptr should now be 3: slave 3 beats slave 0
        s_valid[0] = 1'b1; s_last[0] = 1'b1; s_data[0] = 32'h10;
        s_valid[3] = 1'b1; s_last[3] = 1'b1; s_data[3] = 32'h13;
        m_ready    = 2'b11;
        step();
        vectors++; if (s_ready !== 4'b1000) begin miscompares++; $display("FAIL rr3_grant: got %b exp 1000", s_ready); end
        vectors++; if (m_data !== 32'h13) begin miscompares++; $display("FAIL rr3_data: got %h exp 13", m_data); end
        step();
        s_valid[3] = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr3_bubble: got %b exp 0", busy); end
        step();
        vectors++; if (s_ready !== 4'b0001) begin miscompares++; $display("FAIL rr0_grant: got %b exp 0001", s_ready); end
        step();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] exp_mv;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        clear_inputs();
        for (int i = 0; i < int'(NS); i++) begin
            s_valid[i] = 1'b1;
            s_last[i]  = 1'b1;
            s_id[i]    = IDW'(i % 2);
            s_data[i]  = 32'h20 + 32'(i);
        end
        m_ready = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            exp_mv = (g % 2 == 1) ? 2'b10 : 2'b01;
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_bubble %0d: got %b exp 0", g, busy); end
            step();
            vectors++; if (s_ready !== 4'(1 << g)) begin miscompares++; $display("FAIL rr_grant %0d: got %b exp %b", g, s_ready, 4'(1 << g)); end
            vectors++; if (m_data !== 32'h20 + 32'(g)) begin miscompares++; $display("FAIL rr_data %0d: got %h", g, m_data); end
            vectors++; if (m_valid !== exp_mv) begin miscompares++; $display("FAIL rr_m_valid %0d: got %b exp %b", g, m_valid, exp_mv); end
            step();
            s_valid[g] = 1'b0;
        end
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_end_busy: got %b exp 0", busy); end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [3:0] rr_seq;
        int         bidx;
        rr_seq = 4'b1001;
        bidx   = 0;
        clear_inputs();
        s_valid[1] = 1'b1;
        s_id[1]    = 2'd0;
        s_data[1]  = 32'hB0;
        m_ready    = 2'b01;
        step();
        for (int i = 0; i < 4; i++) begin
            m_ready[0] = rr_seq[i];
            s_data[1]  = 32'hB0 + 32'(bidx);
            s_last[1]  = (bidx == 1);
            #1;
            vectors++; if (s_ready !== (rr_seq[i] ? 4'b0010 : 4'b0000)) begin miscompares++; $display("FAIL bp_s_ready cyc %0d: got %b", i, s_ready); end
            vectors++; if (m_valid !== 2'b01) begin miscompares++; $display("FAIL bp_m_valid cyc %0d: got %b exp 01", i, m_valid); end
            vectors++; if (m_data !== 32'hB0 + 32'(bidx)) begin miscompares++; $display("FAIL bp_data cyc %0d: got %h exp %h", i, m_data, 32'hB0 + 32'(bidx)); end
            vectors++; if (beat_cnt !== 8'(bidx)) begin miscompares++; $display("FAIL bp_cnt cyc %0d: got %0d exp %0d", i, beat_cnt, bidx); end
            step();
            if (rr_seq[i]) bidx++;
        end
        s_valid[1] = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_end_busy: got %b exp 0", busy); end
        vectors++; if (beat_cnt !== 8'd2) begin miscompares++; $display("FAIL bp_end_cnt: got %0d exp 2", beat_cnt); end
        clear_inputs();
    endtask

    task automatic test_bad_id();
        clear_inputs();
        s_valid[3] = 1'b1;
        s_id[3]    = 2'd2;
        s_data[3]  = 32'hC0;
        #1;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL bad_pre_err: got %b exp 0", err); end
        step();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL bad_grant_err: got %b exp 1", err); end
        for (int b = 0; b < 3; b++) begin
            s_last[3] = (b == 2);
            #1;
            vectors++; if (m_valid !== 2'b00) begin miscompares++; $display("FAIL bad_m_valid beat %0d: got %b exp 00", b, m_valid); end
            vectors++; if (s_ready !== 4'b1000) begin miscompares++; $display("FAIL bad_s_ready beat %0d: got %b exp 1000", b, s_ready); end
            vectors++; if (beat_cnt !== 8'(b)) begin miscompares++; $display("FAIL bad_cnt beat %0d: got %0d exp %0d", b, beat_cnt, b); end
            step();
        end
        s_valid[3] = 1'b0;
        s_last[3]  = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bad_end_busy: got %b exp 0", busy); end
        vectors++; if (beat_cnt !== 8'd3) begin miscompares++; $display("FAIL bad_end_cnt: got %0d exp 3", beat_cnt); end
        s_valid[0] = 1'b1;
        s_id[0]    = 2'd1;
        s_data[0]  = 32'hD0;
        s_last[0]  = 1'b1;
        m_ready    = 2'b10;
        step();
        vectors++; if (m_valid !== 2'b10) begin miscompares++; $display("FAIL bad_next_m_valid: got %b exp 10", m_valid); end
        vectors++; if (m_data !== 32'hD0) begin miscompares++; $display("FAIL bad_next_data: got %h exp d0", m_data); end
        vectors++; if (s_ready !== 4'b0001) begin miscompares++; $display("FAIL bad_next_s_ready: got %b exp 0001", s_ready); end
        step();
        s_valid[0] = 1'b0;
        #1;
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL bad_sticky_err: got %b exp 1", err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bad_next_busy: got %b exp 0", busy); end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        s_valid[2] = 1'b1;
        s_id[2]    = 2'd0;
        s_data[2]  = 32'hE0;
        m_ready    = 2'b01;
        step();
        for (int b = 0; b < 2; b++) begin
            s_data[2] = 32'hE0 + 32'(b);
            #1;
            vectors++; if (beat_cnt !== 8'(b)) begin miscompares++; $display("FAIL ar_cnt beat %0d: got %0d exp %0d", b, beat_cnt, b); end
            step();
        end
        s_data[2] = 32'hE2;
        #1;
        vectors++; if (m_valid !== 2'b01) begin miscompares++; $display("FAIL ar_pre_m_valid: got %b exp 01", m_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ar_busy: got %b exp 0", busy); end
        vectors++; if (m_valid !== 2'b00) begin miscompares++; $display("FAIL ar_m_valid: got %b exp 00", m_valid); end
        vectors++; if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL ar_s_ready: got %b exp 0000", s_ready); end
        vectors++; if (m_data !== 32'h0) begin miscompares++; $display("FAIL ar_data: got %h exp 0", m_data); end
        vectors++; if (beat_cnt !== 8'd0) begin miscompares++; $display("FAIL ar_cnt: got %0d exp 0", beat_cnt); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ar_err: got %b exp 0", err); end
        step();
        step();
        vectors++; if (s_ready !== 4'b0000) begin miscompares++; $display("FAIL ar_held_s_ready: got %b exp 0000", s_ready); end
        s_valid[2] = 1'b0;
        rst_n      = 1'b1;
        s_valid[0] = 1'b1; s_last[0] = 1'b1; s_id[0] = 2'd0; s_data[0] = 32'hF0;
        s_valid[1] = 1'b1; s_last[1] = 1'b1; s_id[1] = 2'd1; s_data[1] = 32'hF1;
        m_ready    = 2'b11;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ar_release_busy: got %b exp 0", busy); end
        step();
        vectors++; if (s_ready !== 4'b0001) begin miscompares++; $display("FAIL ar_rr_ptr: got %b exp 0001", s_ready); end
        vectors++; if (m_data !== 32'hF0) begin miscompares++; $display("FAIL ar_release_data: got %h exp f0", m_data); end
        step();
        clear_inputs();
        #1;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ar_release_err: got %b exp 0", err); end
    endtask

    task automatic test_beat_wrap();
        clear_inputs();
        s_valid[1] = 1'b1;
        s_id[1]    = 2'd1;
        m_ready    = 2'b10;
        step();
        for (int b = 0; b < 256; b++) begin
            s_data[1] = 32'h1000 + 32'(b);
            s_last[1] = (b == 255);
            #1;
            vectors++; if (beat_cnt !== 8'(b)) begin miscompares++; $display("FAIL wrap_cnt beat %0d: got %0d exp %0d", b, beat_cnt, b); end
            if (b == 0 || b == 255) begin
                vectors++; if (m_data !== 32'h1000 + 32'(b)) begin miscompares++; $display("FAIL wrap_data beat %0d: got %h", b, m_data); end
            end
            step();
        end
        s_valid[1] = 1'b0;
        s_last[1]  = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wrap_busy: got %b exp 0", busy); end
        vectors++; if (beat_cnt !== 8'd0) begin miscompares++; $display("FAIL wrap_end_cnt: got %0d exp 0", beat_cnt); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_bad_id();
        test_async_reset();
        test_beat_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
